// File: rtl/divcheck_pkg.sv
// Shared types and the residue step used by the divisibility scheduler.
// The step consumes one bit of the word, most significant bit first.
package divcheck_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // 2*r + b stays below 2*divisor, so one conditional subtract restores the range.
    function automatic int unsigned next_residue(
        input int unsigned r,
        input logic        b,
        input int unsigned divisor
    );
        int unsigned sum;
        sum = (r << 1) + {31'd0, b};
        if (sum >= divisor) begin
            sum = sum - divisor;
        end
        return sum;
    endfunction

endpackage

// File: rtl/divcheck_scheduler_residue.sv
// Bit-serial residue engine: clears at the start of a word, then folds in one
// bit per enabled cycle. residue_next exposes the value the next edge would load.
module mod_residue_step
    import divcheck_pkg::*;
#(
    parameter int DIVISOR = 5,
    parameter int REM_W   = $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             bit_in,
    output logic [REM_W-1:0] residue_next
);

    logic [REM_W-1:0] residue_reg;

    always_comb begin
        residue_next = REM_W'(next_residue(32'(residue_reg), bit_in, 32'(DIVISOR)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            residue_reg <= '0;
        end else if (clear) begin
            residue_reg <= '0;
        end else if (enable) begin
            residue_reg <= residue_next;
        end
    end

endmodule

// File: rtl/divcheck_scheduler.sv
// Round-robin scheduler sharing one serial divisibility engine among NREQ
// requesters; each granted word is shifted MSB-first and answered with {id, divisible, remainder}.
module divcheck_scheduler
    import divcheck_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int WIDTH   = 8,
    parameter  int DIVISOR = 5,
    localparam int ID_W    = $clog2(NREQ),
    localparam int REM_W   = $clog2(DIVISOR)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ID_W-1:0]       res_id,
    output logic                  res_divisible,
    output logic [REM_W-1:0]      res_remainder,
    output logic                  busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t            state_reg;
    state_t            state_next;
    logic [WIDTH-1:0]  shift_reg_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [ID_W-1:0]   id_reg;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [ID_W-1:0]   rr_ptr_next;
    logic [ID_W-1:0]   res_id_reg;
    logic              res_divisible_reg;
    logic [REM_W-1:0]  res_remainder_reg;

    logic [WIDTH-1:0]  req_word [NREQ];
    logic [NREQ-1:0]   rot_valid;
    logic              found;
    logic [ID_W-1:0]   offset;
    logic [ID_W:0]     grant_sum;
    logic [ID_W-1:0]   grant_idx;
    logic              accept;
    logic              last_bit;
    logic [REM_W-1:0]  residue_next;

    // Unpack words and rotate the valid vector so rr_ptr lands at position 0.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        logic [ID_W:0] src;

        assign req_word[gi] = req_data[gi*WIDTH +: WIDTH];

        always_comb begin
            src = (ID_W+1)'(gi) + {1'b0, rr_ptr_reg};
            if (src >= (ID_W+1)'(NREQ)) begin
                src = src - (ID_W+1)'(NREQ);
            end
        end

        assign rot_valid[gi] = req_valid[src[ID_W-1:0]];
    end

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && rot_valid[i]) begin
                found  = 1'b1;
                offset = ID_W'(i);
            end
        end
    end

    // Rotate the winning offset back into an absolute requester index.
    always_comb begin
        grant_sum = {1'b0, offset} + {1'b0, rr_ptr_reg};
        if (grant_sum >= (ID_W+1)'(NREQ)) begin
            grant_sum = grant_sum - (ID_W+1)'(NREQ);
        end
        grant_idx = grant_sum[ID_W-1:0];
        if (grant_idx == ID_W'(NREQ - 1)) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = grant_idx + ID_W'(1);
        end
    end

    assign accept   = (state_reg == IDLE) && found;
    assign last_bit = (state_reg == SHIFT) && (bit_cnt_reg == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (found)     state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        res_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                if (found && !reset) begin
                    req_ready[grant_idx] = 1'b1;
                end
            end
            SHIFT: begin
                busy = 1'b1;
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg_reg     <= '0;
            bit_cnt_reg       <= '0;
            id_reg            <= '0;
            rr_ptr_reg        <= '0;
            res_id_reg        <= '0;
            res_divisible_reg <= 1'b0;
            res_remainder_reg <= '0;
        end else if (accept) begin
            shift_reg_reg <= req_word[grant_idx];
            bit_cnt_reg   <= CNT_W'(WIDTH);
            id_reg        <= grant_idx;
            rr_ptr_reg    <= rr_ptr_next;
        end else if (state_reg == SHIFT) begin
            shift_reg_reg <= shift_reg_reg << 1;
            bit_cnt_reg   <= bit_cnt_reg - CNT_W'(1);
            if (last_bit) begin
                res_id_reg        <= id_reg;
                res_remainder_reg <= residue_next;
                res_divisible_reg <= (residue_next == '0);
            end
        end
    end

    mod_residue_step #(
        .DIVISOR (DIVISOR),
        .REM_W   (REM_W)
    ) u_residue (
        .clk          (clk),
        .reset        (reset),
        .clear        (accept),
        .enable       (state_reg == SHIFT),
        .bit_in       (shift_reg_reg[WIDTH-1]),
        .residue_next (residue_next)
    );

    assign res_id        = res_id_reg;
    assign res_divisible = res_divisible_reg;
    assign res_remainder = res_remainder_reg;

endmodule
